d_flip_flop: RTL and testbench

D_FLIP_FLOP -- requirements
Module: d_flip_flop

---
 rtl/d_flip_flop_pkg.sv | 7 +
 rtl/dff_bit.sv | 19 +
 rtl/d_flip_flop.sv | 62 ++++++
 tb/tb_d_flip_flop.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/d_flip_flop_pkg.sv
// Shared constants for the d_flip_flop register block.
package d_flip_flop_pkg;

  localparam int unsigned                DFF_MAX_WIDTH           = 64;
  localparam logic [DFF_MAX_WIDTH-1:0]   DFF_DEFAULT_RESET_VALUE = '0;

endpackage

// File: rtl/dff_bit.sv
// Single-bit storage cell: async active-high reset to a per-bit value, loads d_next every rising edge.
module dff_bit (
  input  logic clk,
  input  logic reset,
  input  logic reset_value,
  input  logic d_next,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= reset_value;
    else       r_q <= d_next;
  end

  assign q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
// WIDTH-bit enabled register with async reset and complemented output, one dff_bit per bit.
// Optional scan chain (bit 0 toward bit WIDTH-1) built when D_FLIP_FLOP_SCAN_EN is defined.
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = DFF_DEFAULT_RESET_VALUE[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
`ifdef D_FLIP_FLOP_SCAN_EN
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar
);

  if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_width_check
    $error("d_flip_flop: WIDTH out of range");
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_d_next;

`ifdef D_FLIP_FLOP_SCAN_EN
  logic [WIDTH-1:0] w_shift;

  if (WIDTH > 1) begin : g_shift_wide
    assign w_shift = {w_q[WIDTH-2:0], scan_in};
  end else begin : g_shift_one
    assign w_shift = scan_in;
  end

  assign scan_out = w_q[WIDTH-1];
`endif

  // Scan takes priority over the functional enable; reset still wins inside each cell.
  always_comb begin
    w_d_next = en ? d : w_q;
`ifdef D_FLIP_FLOP_SCAN_EN
    if (scan_en) w_d_next = w_shift;
`endif
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit u_bit (
      .clk         (clk),
      .reset       (reset),
      .reset_value (RESET_VALUE[i]),
      .d_next      (w_d_next[i]),
      .q           (w_q[i])
    );
  end

  assign q     = w_q;
  assign q_bar = ~w_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed-vector bench for d_flip_flop: 1-bit and 8-bit instances, plus a 4-bit scan instance when enabled.
module tb_d_flip_flop;

  logic       clk = 1'b0;
  logic       reset;
  logic       en1, en8;
  logic [0:0] d1;
  logic [7:0] d8;
  logic [0:0] q1, qb1;
  logic [7:0] q8, qb8, q8r, qb8r;

  int n_tests = 0;
  int n_fail  = 0;

  always #4 clk = ~clk;

`ifdef D_FLIP_FLOP_SCAN_EN
  logic       scan_en, scan_in, en4;
  logic [3:0] d4, q4, qb4;
  logic       so1, so8, so8r, so4;
`endif

  d_flip_flop #(.WIDTH(1)) u_dff1 (
    .clk(clk), .reset(reset), .en(en1), .d(d1),
`ifdef D_FLIP_FLOP_SCAN_EN
    .scan_en(1'b0), .scan_in(1'b0), .scan_out(so1),
`endif
    .q(q1), .q_bar(qb1)
  );

  d_flip_flop #(.WIDTH(8)) u_dff8 (
    .clk(clk), .reset(reset), .en(en8), .d(d8),
`ifdef D_FLIP_FLOP_SCAN_EN
    .scan_en(1'b0), .scan_in(1'b0), .scan_out(so8),
`endif
    .q(q8), .q_bar(qb8)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(8'h5A)) u_dff8r (
    .clk(clk), .reset(reset), .en(en8), .d(d8),
`ifdef D_FLIP_FLOP_SCAN_EN
    .scan_en(1'b0), .scan_in(1'b0), .scan_out(so8r),
`endif
    .q(q8r), .q_bar(qb8r)
  );

`ifdef D_FLIP_FLOP_SCAN_EN
  d_flip_flop #(.WIDTH(4)) u_dff4 (
    .clk(clk), .reset(reset), .en(en4), .d(d4),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(so4),
    .q(q4), .q_bar(qb4)
  );
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en1   = 1'b1;
    en8   = 1'b1;
    d1    = 1'b1;
    d8    = 8'hFF;
`ifdef D_FLIP_FLOP_SCAN_EN
    en4     = 1'b0;
    d4      = 4'h0;
    scan_en = 1'b0;
    scan_in = 1'b0;
`endif

    // Power-up: reset held across running clock with d=1.
    #1;
    check("rst_q1",    64'(q1),   64'h0);
    check("rst_qb1",   64'(qb1),  64'h1);
    check("rst_q8",    64'(q8),   64'h00);
    check("rst_qb8",   64'(qb8),  64'hFF);
    check("rst_q8r",   64'(q8r),  64'h5A);
    check("rst_qb8r",  64'(qb8r), 64'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pwr_q1",  64'(q1),  64'h0);
      check("pwr_qb1", 64'(qb1), 64'h1);
    end

    // Release reset mid-cycle; first load happens on the following edge.
    #2 reset = 1'b0;
    #1;
    check("rel_q1", 64'(q1), 64'h0);
    tick();
    check("cap0_q1",  64'(q1),  64'h1);
    check("cap0_qb1", 64'(qb1), 64'h0);
    check("cap0_q8",  64'(q8),  64'hFF);
    check("cap0_q8r", 64'(q8r), 64'hFF);

    // Capture sequence on the 1-bit instance.
    d1 = 1'b0;
    #4 d1 = 1'b1;
    tick();
    check("cap1_q1",  64'(q1),  64'h1);
    check("cap1_qb1", 64'(qb1), 64'h0);
    tick();
    check("cap2_q1",  64'(q1),  64'h1);
    d1 = 1'b0;
    #4 d1 = 1'b1;
    tick();
    check("cap3_q1", 64'(q1), 64'h1);
    d1 = 1'b0;
    tick();
    check("cap4_q1",  64'(q1),  64'h0);
    check("cap4_qb1", 64'(qb1), 64'h1);

    // Edge triggering: d pulses between edges must not reach q.
    d1 = 1'b1;
    #2 check("edge_lo_mid", 64'(q1), 64'h0);
    #1 d1 = 1'b0;
    tick();
    check("edge_lo_end", 64'(q1), 64'h0);
    d1 = 1'b1;
    tick();
    check("edge_set", 64'(q1), 64'h1);
    d1 = 1'b0;
    #2 check("edge_hi_mid", 64'(q1), 64'h1);
    #1 d1 = 1'b1;
    tick();
    check("edge_hi_end", 64'(q1), 64'h1);

    // Hold with en low.
    d8 = 8'h3C;
    tick();
    check("load_q8",  64'(q8),  64'h3C);
    check("load_qb8", 64'(qb8), 64'hC3);
    en8 = 1'b0;
    d8  = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q8",  64'(q8),  64'h3C);
      check("hold_qb8", 64'(qb8), 64'hC3);
    end
    en8 = 1'b1;
    tick();
    check("reen_q8", 64'(q8), 64'hA5);

    // Asynchronous reset mid-cycle, held across an edge.
    d8 = 8'hFF;
    tick();
    check("pre_ar_q8", 64'(q8), 64'hFF);
    #2 reset = 1'b1;
    #1;
    check("ar_q8",   64'(q8),   64'h00);
    check("ar_qb8",  64'(qb8),  64'hFF);
    check("ar_q8r",  64'(q8r),  64'h5A);
    check("ar_qb8r", 64'(qb8r), 64'hA5);
    check("ar_q1",   64'(q1),   64'h0);
    tick();
    check("ar_hold_q8",  64'(q8),  64'h00);
    check("ar_hold_q8r", 64'(q8r), 64'h5A);
    #2 reset = 1'b0;
    d8 = 8'h96;
    tick();
    check("post_ar_q8",  64'(q8),  64'h96);
    check("post_ar_q8r", 64'(q8r), 64'h96);
    check("post_ar_qb8", 64'(qb8), 64'h69);

`ifdef D_FLIP_FLOP_SCAN_EN
    // Scan shift of ones into a cleared 4-bit register, with en low.
    check("scan_init", 64'(q4), 64'h0);
    scan_en = 1'b1;
    scan_in = 1'b1;
    tick(); check("scan_s1", 64'(q4), 64'h1); check("scan_so1", 64'(so4), 64'h0);
    tick(); check("scan_s2", 64'(q4), 64'h3);
    tick(); check("scan_s3", 64'(q4), 64'h7); check("scan_so3", 64'(so4), 64'h0);
    tick(); check("scan_s4", 64'(q4), 64'hF); check("scan_so4", 64'(so4), 64'h1);
    scan_in = 1'b0;
    tick(); check("scan_s5", 64'(q4), 64'hE);
    scan_en = 1'b0;
    d4      = 4'h5;
    tick(); check("scan_off_hold", 64'(q4), 64'hE);
    en4 = 1'b1;
    tick(); check("scan_off_load", 64'(q4), 64'h5);
    scan_en = 1'b1;
    #2 reset = 1'b1;
    #1 check("scan_rst", 64'(q4), 64'h0);
    tick(); check("scan_rst_hold", 64'(q4), 64'h0);
    #2 reset = 1'b0;
    scan_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
